// File: rtl/boot_mem.sv
// boot_mem: wait-stated boot memory with a write-protect latch and a two-bit
// control/status register (err in bit 1, wp in bit 0).
// The array comes up holding the built-in boot stub image and is never
// cleared by reset, so code written into it survives a reset.
module boot_mem #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_STATES = 2,
  parameter     INIT_FILE   = "stub.hex"
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sel,
  input  logic          csel,
  input  logic          rd,
  input  logic          wr,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          ready,
  output logic          wp,
  output logic          err
);

  localparam int DEPTH = 2 ** AW;

  // The stub image is compiled in so that no external file is needed at build
  // time. Any other image name leaves the array zeroed for the integration
  // flow to preload.
  localparam bit STUB = (INIT_FILE == "stub.hex");

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  logic [DW-1:0] mem [DEPTH] = '{
    0:       DW'(STUB ? 8'h4F : 8'h00),
    1:       DW'(STUB ? 8'h1F : 8'h00),
    3:       DW'(STUB ? 8'h86 : 8'h00),
    5:       DW'(STUB ? 8'h4C : 8'h00),
    16:      DW'(STUB ? 8'h12 : 8'h00),
    254:     DW'(STUB ? 8'hFF : 8'h00),
    default: '0
  };

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] la;
  logic [DW-1:0] ld;
  logic          lrd;
  logic          lwr;
  logic          lsel;
  logic          lcsel;

  logic          isreq;
  logic          isctl;
  logic          isread;
  logic          iswrite;
  logic          memwe;
  logic          newerr;

  assign isreq = (sel | csel) & (rd | wr);

  // Decode the latched request: csel wins over sel, and rd wins over wr.
  always_comb begin
    isctl   = lcsel;
    isread  = lrd;
    iswrite = lwr & ~lrd;
    memwe   = (state == DONE) & ~isctl & iswrite & ~wp;
    newerr  = (lrd & lwr) | (lsel & lcsel) | (~isctl & iswrite & wp);
  end

  // Access sequencer: latch the request, count wait states, then complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      dout  <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
      wp    <= 1'b1;
      la    <= '0;
      ld    <= '0;
      lrd   <= 1'b0;
      lwr   <= 1'b0;
      lsel  <= 1'b0;
      lcsel <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (isreq) begin
            la    <= a;
            ld    <= din;
            lrd   <= rd;
            lwr   <= wr;
            lsel  <= sel;
            lcsel <= csel;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end else begin
              state <= DONE;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
          if (isread) begin
            dout <= isctl ? DW'({err, wp}) : mem[la];
          end
          if (newerr) begin
            err <= 1'b1;
          end else if (isctl & isread) begin
            err <= 1'b0;
          end
          if (isctl & iswrite) begin
            wp <= ld[0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array write port, deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (memwe) begin
      mem[la] <= ld;
    end
  end

endmodule

// File: tb/tb_boot_mem.sv
// tb_boot_mem: checks a two-wait-state and a zero-wait-state boot_mem against
// a transaction-level model of the memory, write-protect and error rules.
module tb_boot_mem;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_n = 1'b0;
  logic       sel0  = 1'b0;
  logic       csel0 = 1'b0;
  logic       sel2  = 1'b0;
  logic       csel2 = 1'b0;
  logic       rd    = 1'b0;
  logic       wr    = 1'b0;
  logic [7:0] a     = 8'h00;
  logic [7:0] din   = 8'h00;
  logic [7:0] dout0, dout2;
  logic       ready0, ready2, wp0, wp2, err0, err2;

  int testsRun  = 0;
  int failCount = 0;
  bit sawReady;

  // Index 0 models the zero-wait-state build, index 1 the two-wait-state build.
  logic [7:0] refMem  [2][256];
  logic       refWp   [2];
  logic       refErr  [2];
  logic [7:0] refDout [2];

  boot_mem #(.AW(8), .DW(8), .WAIT_STATES(2), .INIT_FILE("stub.hex")) dut2 (
    .clk(clock), .rst_n(rst_n), .sel(sel2), .csel(csel2), .rd(rd), .wr(wr),
    .a(a), .din(din), .dout(dout2), .ready(ready2), .wp(wp2), .err(err2)
  );

  boot_mem #(.AW(8), .DW(8), .WAIT_STATES(0), .INIT_FILE("stub.hex")) dut0 (
    .clk(clock), .rst_n(rst_n), .sel(sel0), .csel(csel0), .rd(rd), .wr(wr),
    .a(a), .din(din), .dout(dout0), .ready(ready0), .wp(wp0), .err(err0)
  );

  function automatic logic readyOf(input int k);
    return (k != 0) ? ready2 : ready0;
  endfunction

  function automatic logic [7:0] doutOf(input int k);
    return (k != 0) ? dout2 : dout0;
  endfunction

  function automatic logic errOf(input int k);
    return (k != 0) ? err2 : err0;
  endfunction

  function automatic logic wpOf(input int k);
    return (k != 0) ? wp2 : wp0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic driveSel(input int k, input logic s, input logic cs);
    if (k != 0) begin
      sel2  = s;
      csel2 = cs;
    end else begin
      sel0  = s;
      csel0 = cs;
    end
  endtask

  task automatic loadImage();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) refMem[k][i] = 8'h00;
      refMem[k][8'h00] = 8'h4F;
      refMem[k][8'h01] = 8'h1F;
      refMem[k][8'h03] = 8'h86;
      refMem[k][8'h05] = 8'h4C;
      refMem[k][8'h10] = 8'h12;
      refMem[k][8'hFE] = 8'hFF;
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      refWp[k]   = 1'b1;
      refErr[k]  = 1'b0;
      refDout[k] = 8'h00;
    end
  endtask

  // One complete transaction as the register map describes it.
  task automatic modelAccess(input int k, input logic s, input logic cs, input logic r,
                             input logic w, input logic [7:0] addr, input logic [7:0] d);
    logic newErr;
    newErr = (r && w) || (s && cs) || (!cs && !r && w && refWp[k]);
    if (cs) begin
      if (r) begin
        refDout[k] = {6'b0, refErr[k], refWp[k]};
        refErr[k]  = newErr;
      end else begin
        refWp[k] = d[0];
        if (newErr) refErr[k] = 1'b1;
      end
    end else begin
      if (r) refDout[k] = refMem[k][addr];
      else if (!refWp[k]) refMem[k][addr] = d;
      if (newErr) refErr[k] = 1'b1;
    end
  endtask

  task automatic applyReset();
    @(negedge clock);
    #1 rst_n = 1'b0;
    modelReset();
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("reset%0d dout", k), doutOf(k), 8'h00);
      checkOutput($sformatf("reset%0d ready", k), readyOf(k), 0);
      checkOutput($sformatf("reset%0d err", k), errOf(k), 0);
      checkOutput($sformatf("reset%0d wp", k), wpOf(k), 1);
    end
    #1 rst_n = 1'b1;
  endtask

  // Issue one request, scribble a conflicting request on the bus while it is
  // in flight, then check latency, results and the single-cycle ready pulse.
  task automatic applyStimulus(input int k, input logic s, input logic cs, input logic r,
                               input logic w, input logic [7:0] addr, input logic [7:0] d,
                               input string tag);
    int lat;
    bit seen;
    if (clock) @(negedge clock);
    driveSel(k, s, cs);
    rd  = r;
    wr  = w;
    a   = addr;
    din = d;
    @(posedge clock);
    #1;
    modelAccess(k, s, cs, r, w, addr, d);
    driveSel(k, 1'b1, 1'b0);
    rd  = 1'b0;
    wr  = 1'b1;
    a   = ~addr;
    din = ~d;
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(posedge clock);
      #1;
      if (readyOf(k)) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    driveSel(k, 1'b0, 1'b0);
    rd = 1'b0;
    wr = 1'b0;
    checkOutput({tag, " latency"}, lat, (k != 0) ? 3 : 1);
    checkOutput({tag, " dout"}, doutOf(k), refDout[k]);
    checkOutput({tag, " err"}, errOf(k), refErr[k]);
    checkOutput({tag, " wp"}, wpOf(k), refWp[k]);
    @(posedge clock);
    #1;
    checkOutput({tag, " pulse"}, readyOf(k), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    loadImage();
    modelReset();
    applyReset();

    // Stub image reads through the two-wait-state build.
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, "read 00");
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFE, 8'h00, "read FE");
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, "read 01");

    // Locked write is refused and flagged; a status read reports and clears it.
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 8'hA5, "locked write");
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00, "locked readback");
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, "status read");
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, "status reread");

    // Unlock, write, and confirm the data survives a reset that relocks.
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, "unlock");
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 8'hA5, "write 20");
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00, "read 20");
    applyReset();
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00, "read 20 after reset");

    // Reset during the wait states aborts the write.
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, "unlock again");
    @(negedge clock);
    sel2 = 1'b1;
    wr   = 1'b1;
    rd   = 1'b0;
    a    = 8'h10;
    din  = 8'h5A;
    @(posedge clock);
    #1;
    sel2 = 1'b0;
    wr   = 1'b0;
    @(posedge clock);
    #2 rst_n = 1'b0;
    modelReset();
    #2 rst_n = 1'b1;
    sawReady = 1'b0;
    repeat (6) begin
      @(posedge clock);
      #1;
      if (ready2) sawReady = 1'b1;
    end
    checkOutput("midreset ready", sawReady, 0);
    checkOutput("midreset wp", wp2, 1);
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h00, "midreset read 10");

    // rd+wr together is a read with an error; sel+csel is a control access.
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, "unlock third");
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 8'h77, "rd wr both");
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 8'h00, "read 05 again");
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 8'h00, "sel csel read");
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, "status clear");

    // Zero-wait-state build: single read, then back-to-back reads.
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 8'h00, "ws0 read 03");
    if (clock) @(negedge clock);
    sel0 = 1'b1;
    rd   = 1'b1;
    a    = 8'h03;
    @(posedge clock);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock);
      #1;
      checkOutput($sformatf("ws0 back-to-back %0d", c), ready0, c % 2);
    end
    sel0 = 1'b0;
    rd   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("ws0 back-to-back dout", dout0, 8'h86);

    // Randomized traffic on both builds over a scratch region.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(k, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, "random unlock");
      for (int i = 0; i < 16; i++) begin
        applyStimulus(k, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80 + 8'(i), 8'($urandom), "fill");
      end
      for (int i = 0; i < 30; i++) begin
        logic s, cs, r, w;
        int pick;
        s    = 1'($urandom_range(0, 1));
        cs   = s ? ($urandom_range(0, 3) == 0) : 1'b1;
        pick = $urandom_range(0, 5);
        r    = (pick <= 2) || (pick == 5);
        w    = (pick >= 3);
        applyStimulus(k, s, cs, r, w, 8'h80 + 8'($urandom_range(0, 15)), 8'($urandom),
                      $sformatf("random%0d.%0d", k, i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
